// File: rtl/xpu_vpu_pc_tn_vlsu_pkg.sv
// Shared definitions for the VLSU load-uop sequencer: widths, state encoding
// and the mask helper used when a uop is captured.
package xpu_vpu_pc_tn_vlsu_pkg;

    localparam int UID_W  = 8;   // uop id width
    localparam int ENUM   = 16;  // elements per lane / mask width
    localparam int ELEN_W = 5;   // element count / index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CMPLT = 2'd2
    } ld_seq_state_t;

    // An unmasked uop behaves as if every mask bit were set.
    function automatic logic [ENUM-1:0] eff_mask(input logic vm,
                                                 input logic [ENUM-1:0] mask);
        return vm ? {ENUM{1'b1}} : mask;
    endfunction

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_seq_if.sv
// Bundle of the uop-in, request-out and completion-out signals of the load
// sequencer. The master side is the surrounding pipeline, the slave side is
// the sequencer itself.
//
// Handshake rule for uop_* and req_*: a transfer happens on a rising clock
// edge where valid and ready are both high; once valid is raised the payload
// holds until that transfer (or a flush/reset), and ready may depend on the
// current cycle only. cmplt_* is a bare one-cycle pulse with no ready.
interface xpu_vpu_pc_tn_vlsu_ld_seq_if;
    import xpu_vpu_pc_tn_vlsu_pkg::*;

    logic              uop_vld;
    logic              uop_rdy;
    logic [UID_W-1:0]  uop_uid;
    logic [2:0]        uop_type;
    logic [1:0]        uop_eew;
    logic [1:0]        uop_nf;
    logic              uop_vm;
    logic [ENUM-1:0]   uop_vmask_data;
    logic [ELEN_W-1:0] uop_ele_len;
    logic [ELEN_W-1:0] uop_vstart_len;
    logic              uop_op_last;

    logic              req_vld;
    logic              req_rdy;
    logic [UID_W-1:0]  req_uid;
    logic [2:0]        req_type;
    logic [1:0]        req_eew;
    logic [3:0]        req_eidx;
    logic [1:0]        req_field;
    logic              req_last;

    logic              cmplt_vld;
    logic [UID_W-1:0]  cmplt_uid;
    logic              cmplt_op_last;

    modport master (
        output uop_vld, uop_uid, uop_type, uop_eew, uop_nf, uop_vm,
               uop_vmask_data, uop_ele_len, uop_vstart_len, uop_op_last,
        input  uop_rdy,
        input  req_vld, req_uid, req_type, req_eew, req_eidx, req_field, req_last,
        output req_rdy,
        input  cmplt_vld, cmplt_uid, cmplt_op_last
    );

    modport slave (
        input  uop_vld, uop_uid, uop_type, uop_eew, uop_nf, uop_vm,
               uop_vmask_data, uop_ele_len, uop_vstart_len, uop_op_last,
        output uop_rdy,
        output req_vld, req_uid, req_type, req_eew, req_eidx, req_field, req_last,
        input  req_rdy,
        output cmplt_vld, cmplt_uid, cmplt_op_last
    );

endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_seq_rem.sv
// Remaining-active-element detect: is any active element left strictly
// above the current index and below the end of the range?
module xpu_vpu_pc_tn_vlsu_ld_seq_rem
    import xpu_vpu_pc_tn_vlsu_pkg::*;
(
    input  logic [ENUM-1:0]   mask,
    input  logic [ELEN_W-1:0] eidx,
    input  logic [ELEN_W-1:0] ele_len,
    output logic              rem_any
);

    logic [ENUM-1:0] rem_bits;

    // Keep only active bits in the window (eidx, ele_len).
    always_comb begin
        rem_bits = '0;
        for (int j = 0; j < ENUM; j++) begin
            if ((ELEN_W'(j) > eidx) && (ELEN_W'(j) < ele_len)) begin
                rem_bits[j] = mask[j];
            end
        end
    end

    assign rem_any = |rem_bits;

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_seq.sv
// Load-uop sequencer: expands one captured load uop into per-element,
// per-field requests toward the VLSU load pipe, skips masked-off elements at
// one per cycle, and pulses completion once the whole range is walked.
module xpu_vpu_pc_tn_vlsu_ld_seq
    import xpu_vpu_pc_tn_vlsu_pkg::*;
(
    input  logic                          forever_cpuclk,
    input  logic                          vpu_rst,
    input  logic                          vlsu_ld_flush,
    xpu_vpu_pc_tn_vlsu_ld_seq_if.slave    ld_if,
    output ld_seq_state_t                 state_dbg
);

    ld_seq_state_t     state;
    logic [UID_W-1:0]  uid_q;
    logic [2:0]        type_q;
    logic [1:0]        eew_q;
    logic [1:0]        nf_q;
    logic [ENUM-1:0]   mask_q;     // effective mask, vm already folded in
    logic [ELEN_W-1:0] ele_len_q;
    logic [ELEN_W-1:0] eidx_q;
    logic [1:0]        field_q;
    logic              op_last_q;

    logic              kill;
    logic              elem_act;
    logic              field_end;
    logic [ELEN_W-1:0] eidx_inc;
    logic              range_end;
    logic              rem_any;

    // Reset and flush both suppress every handshake in the current cycle.
    assign kill      = vpu_rst | vlsu_ld_flush;
    assign elem_act  = mask_q[eidx_q[3:0]];
    assign field_end = (field_q == nf_q);
    assign eidx_inc  = eidx_q + ELEN_W'(1);
    assign range_end = (eidx_inc == ele_len_q);

    xpu_vpu_pc_tn_vlsu_ld_seq_rem u_rem (
        .mask    (mask_q),
        .eidx    (eidx_q),
        .ele_len (ele_len_q),
        .rem_any (rem_any)
    );

    assign ld_if.uop_rdy       = (state == IDLE) && !kill;
    assign ld_if.req_vld       = (state == ISSUE) && elem_act && !kill;
    assign ld_if.req_uid       = uid_q;
    assign ld_if.req_type      = type_q;
    assign ld_if.req_eew       = eew_q;
    assign ld_if.req_eidx      = eidx_q[3:0];
    assign ld_if.req_field     = field_q;
    assign ld_if.req_last      = field_end && !rem_any;
    assign ld_if.cmplt_vld     = (state == CMPLT) && !kill;
    assign ld_if.cmplt_uid     = uid_q;
    assign ld_if.cmplt_op_last = op_last_q;
    assign state_dbg           = state;

    // Sequencer FSM with capture, element and field counters.
    always_ff @(posedge forever_cpuclk) begin
        if (vpu_rst) begin
            state     <= IDLE;
            uid_q     <= '0;
            type_q    <= '0;
            eew_q     <= '0;
            nf_q      <= '0;
            mask_q    <= '0;
            ele_len_q <= '0;
            eidx_q    <= '0;
            field_q   <= '0;
            op_last_q <= 1'b0;
        end else if (vlsu_ld_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_if.uop_vld) begin
                        uid_q     <= ld_if.uop_uid;
                        type_q    <= ld_if.uop_type;
                        eew_q     <= ld_if.uop_eew;
                        nf_q      <= ld_if.uop_nf;
                        mask_q    <= eff_mask(ld_if.uop_vm, ld_if.uop_vmask_data);
                        ele_len_q <= ld_if.uop_ele_len;
                        op_last_q <= ld_if.uop_op_last;
                        eidx_q    <= ld_if.uop_vstart_len;
                        field_q   <= '0;
                        state     <= (ld_if.uop_vstart_len >= ld_if.uop_ele_len) ? CMPLT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (elem_act) begin
                        if (ld_if.req_rdy) begin
                            if (field_end) begin
                                field_q <= '0;
                                eidx_q  <= eidx_inc;
                                if (range_end) state <= CMPLT;
                            end else begin
                                field_q <= field_q + 2'd1;
                            end
                        end
                    end else begin
                        eidx_q <= eidx_inc;
                        if (range_end) state <= CMPLT;
                    end
                end
                CMPLT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_ld_seq.sv
// Directed bench for the VLSU load-uop sequencer.
module tb_xpu_vpu_pc_tn_vlsu_ld_seq;
    import xpu_vpu_pc_tn_vlsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    ld_seq_state_t state_dbg;

    always #5 clk = ~clk;

    xpu_vpu_pc_tn_vlsu_ld_seq_if ld_if ();

    xpu_vpu_pc_tn_vlsu_ld_seq dut (
        .forever_cpuclk (clk),
        .vpu_rst        (rst),
        .vlsu_ld_flush  (flush),
        .ld_if          (ld_if),
        .state_dbg      (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    // scoreboard: {uid, eidx, field, last}
    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    int          first_c, cmplt_c, n_cmplt, vld_cycles, stab_err;
    logic [7:0]  c_uid;
    logic        c_last;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_uop(input logic [7:0] uid, input logic [2:0] typ,
                            input logic [1:0] eew, input logic [1:0] nf,
                            input logic vm, input logic [15:0] mask,
                            input logic [4:0] len, input logic [4:0] vst,
                            input logic ol);
        ld_if.uop_uid        = uid;
        ld_if.uop_type       = typ;
        ld_if.uop_eew        = eew;
        ld_if.uop_nf         = nf;
        ld_if.uop_vm         = vm;
        ld_if.uop_vmask_data = mask;
        ld_if.uop_ele_len    = len;
        ld_if.uop_vstart_len = vst;
        ld_if.uop_op_last    = ol;
        ld_if.uop_vld        = 1'b1;
        step();
        ld_if.uop_vld        = 1'b0;
    endtask

    // Monitor: runs cycles from T+1 until the completion pulse (bounded),
    // recording accepted requests and stall stability.
    task automatic drain(input int budget, input bit rand_rdy);
        logic [14:0] cur, prev;
        bit stall;
        stall = 1'b0;
        prev = '0;
        obs_q.delete();
        first_c = 0; cmplt_c = 0; n_cmplt = 0; vld_cycles = 0; stab_err = 0;
        c_uid = '0; c_last = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            ld_if.req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cur = {ld_if.req_uid, ld_if.req_eidx, ld_if.req_field, ld_if.req_last};
            if (stall && (ld_if.req_vld !== 1'b1 || cur !== prev)) stab_err++;
            if (ld_if.req_vld === 1'b1) begin
                vld_cycles++;
                if (first_c == 0) first_c = c;
                if (ld_if.req_rdy) obs_q.push_back(cur);
            end
            stall = (ld_if.req_vld === 1'b1) && !ld_if.req_rdy;
            prev  = cur;
            if (ld_if.cmplt_vld === 1'b1) begin
                n_cmplt++;
                cmplt_c = c;
                c_uid   = ld_if.cmplt_uid;
                c_last  = ld_if.cmplt_op_last;
            end
            step();
            if (cmplt_c != 0) break;
        end
        ld_if.req_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        n_vec++; if (ld_if.uop_rdy !== 1'b0) begin n_err++; $display("FAIL rst_uop_rdy got %b want 0", ld_if.uop_rdy); end
        n_vec++; if (ld_if.req_vld !== 1'b0) begin n_err++; $display("FAIL rst_req_vld got %b want 0", ld_if.req_vld); end
        n_vec++; if (ld_if.cmplt_vld !== 1'b0) begin n_err++; $display("FAIL rst_cmplt_vld got %b want 0", ld_if.cmplt_vld); end
        n_vec++; if ({ld_if.req_eidx, ld_if.req_field} !== 6'd0) begin n_err++; $display("FAIL rst_eidx_field got %h want 0", {ld_if.req_eidx, ld_if.req_field}); end
        n_vec++; if ({ld_if.req_uid, ld_if.cmplt_uid} !== 16'd0) begin n_err++; $display("FAIL rst_uids got %h want 0", {ld_if.req_uid, ld_if.cmplt_uid}); end
        n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want 0", state_dbg); end
        rst = 1'b0;
        #1;
        n_vec++; if (ld_if.uop_rdy !== 1'b1) begin n_err++; $display("FAIL rst_release_rdy got %b want 1", ld_if.uop_rdy); end
        step();
    endtask

    task automatic test_unmasked();
        logic [14:0] got;
        exp_q.delete();
        exp_q.push_back({8'h11, 4'd0, 2'd0, 1'b0});
        exp_q.push_back({8'h11, 4'd1, 2'd0, 1'b0});
        exp_q.push_back({8'h11, 4'd2, 2'd0, 1'b0});
        exp_q.push_back({8'h11, 4'd3, 2'd0, 1'b1});
        send_uop(8'h11, 3'd2, 2'd1, 2'd0, 1'b1, 16'h0000, 5'd4, 5'd0, 1'b1);
        drain(100, 1'b0);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL unm_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL unm_req%0d got %h want %h", i, got, exp_q[i]); end
        end
        n_vec++; if (first_c != 1) begin n_err++; $display("FAIL unm_first_req got %0d want 1", first_c); end
        n_vec++; if (cmplt_c != 5) begin n_err++; $display("FAIL unm_cmplt_cycle got %0d want 5", cmplt_c); end
        n_vec++; if ({c_uid, c_last} !== {8'h11, 1'b1}) begin n_err++; $display("FAIL unm_cmplt_info got %h want %h", {c_uid, c_last}, {8'h11, 1'b1}); end
        #1;
        n_vec++; if ({ld_if.cmplt_vld, ld_if.uop_rdy} !== 2'b01) begin n_err++; $display("FAIL unm_after got %b want 01", {ld_if.cmplt_vld, ld_if.uop_rdy}); end
    endtask

    task automatic test_masked_seg();
        logic [14:0] got;
        exp_q.delete();
        exp_q.push_back({8'h22, 4'd0, 2'd0, 1'b0});
        exp_q.push_back({8'h22, 4'd0, 2'd1, 1'b0});
        exp_q.push_back({8'h22, 4'd2, 2'd0, 1'b0});
        exp_q.push_back({8'h22, 4'd2, 2'd1, 1'b1});
        send_uop(8'h22, 3'd1, 2'd0, 2'd1, 1'b0, 16'h0005, 5'd4, 5'd0, 1'b0);
        drain(100, 1'b0);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL msk_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL msk_req%0d got %h want %h", i, got, exp_q[i]); end
        end
        n_vec++; if (vld_cycles != 4) begin n_err++; $display("FAIL msk_vld_cycles got %0d want 4", vld_cycles); end
        n_vec++; if (cmplt_c != 7) begin n_err++; $display("FAIL msk_cmplt_cycle got %0d want 7", cmplt_c); end
        n_vec++; if ({c_uid, c_last} !== {8'h22, 1'b0}) begin n_err++; $display("FAIL msk_cmplt_info got %h want %h", {c_uid, c_last}, {8'h22, 1'b0}); end
        #1;
        n_vec++; if (ld_if.cmplt_vld !== 1'b0) begin n_err++; $display("FAIL msk_single_pulse got %b want 0", ld_if.cmplt_vld); end
    endtask

    task automatic test_empty();
        send_uop(8'h44, 3'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 5'd8, 5'd0, 1'b1);
        drain(100, 1'b0);
        n_vec++; if (vld_cycles != 0) begin n_err++; $display("FAIL empty_mask_vld got %0d want 0", vld_cycles); end
        n_vec++; if (cmplt_c != 9) begin n_err++; $display("FAIL empty_mask_cmplt got %0d want 9", cmplt_c); end
        send_uop(8'h45, 3'd0, 2'd0, 2'd0, 1'b1, 16'h0000, 5'd5, 5'd5, 1'b0);
        drain(100, 1'b0);
        n_vec++; if (cmplt_c != 1) begin n_err++; $display("FAIL empty_range_cmplt got %0d want 1", cmplt_c); end
        n_vec++; if (vld_cycles != 0) begin n_err++; $display("FAIL empty_range_vld got %0d want 0", vld_cycles); end
        #1;
        n_vec++; if (ld_if.uop_rdy !== 1'b1) begin n_err++; $display("FAIL empty_range_rdy got %b want 1", ld_if.uop_rdy); end
    endtask

    task automatic test_back_to_back_stall();
        logic [14:0] got;
        exp_q.delete();
        for (int e = 1; e <= 2; e++)
            for (int f = 0; f < 4; f++)
                exp_q.push_back({8'h33, 4'(e), 2'(f), (e == 2 && f == 3)});
        send_uop(8'h33, 3'd5, 2'd2, 2'd3, 1'b1, 16'h0000, 5'd3, 5'd1, 1'b1);
        drain(400, 1'b1);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL stall_req%0d got %h want %h", i, got, exp_q[i]); end
        end
        n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL stall_stability got %0d want 0", stab_err); end
        n_vec++; if ((n_cmplt != 1) || (c_uid !== 8'h33)) begin n_err++; $display("FAIL stall_cmplt got %0d/%h want 1/33", n_cmplt, c_uid); end
    endtask

    task automatic test_flush();
        logic [14:0] got;
        send_uop(8'h55, 3'd3, 2'd2, 2'd0, 1'b1, 16'h0000, 5'd8, 5'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            ld_if.req_rdy = 1'b1;
            #1;
            n_vec++; if ({ld_if.req_vld, ld_if.req_eidx, ld_if.req_type, ld_if.req_eew} !== {1'b1, 4'(c), 3'd3, 2'd2})
                begin n_err++; $display("FAIL flush_pre%0d got %h want %h", c, {ld_if.req_vld, ld_if.req_eidx, ld_if.req_type, ld_if.req_eew}, {1'b1, 4'(c), 3'd3, 2'd2}); end
            step();
        end
        flush = 1'b1;
        ld_if.uop_uid = 8'h99; ld_if.uop_vm = 1'b1; ld_if.uop_nf = 2'd0;
        ld_if.uop_ele_len = 5'd4; ld_if.uop_vstart_len = 5'd0; ld_if.uop_vld = 1'b1;
        #1;
        n_vec++; if ({ld_if.req_vld, ld_if.uop_rdy, ld_if.cmplt_vld} !== 3'b000) begin n_err++; $display("FAIL flush_cycle got %b want 000", {ld_if.req_vld, ld_if.uop_rdy, ld_if.cmplt_vld}); end
        n_vec++; if (ld_if.req_eidx !== 4'd2) begin n_err++; $display("FAIL flush_eidx got %0d want 2", ld_if.req_eidx); end
        step();
        flush = 1'b0;
        ld_if.uop_vld = 1'b0;
        #1;
        n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL flush_idle got %0d want 0", state_dbg); end
        n_vec++; if ({ld_if.cmplt_vld, ld_if.uop_rdy, ld_if.req_vld} !== 3'b010) begin n_err++; $display("FAIL flush_after got %b want 010", {ld_if.cmplt_vld, ld_if.uop_rdy, ld_if.req_vld}); end
        exp_q.delete();
        exp_q.push_back({8'h56, 4'd3, 2'd0, 1'b0});
        exp_q.push_back({8'h56, 4'd4, 2'd0, 1'b1});
        send_uop(8'h56, 3'd0, 2'd0, 2'd0, 1'b1, 16'h0000, 5'd5, 5'd3, 1'b1);
        drain(100, 1'b0);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL post_flush_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL post_flush_req%0d got %h want %h", i, got, exp_q[i]); end
        end
        n_vec++; if ((cmplt_c != 3) || ({c_uid, c_last} !== {8'h56, 1'b1})) begin n_err++; $display("FAIL post_flush_cmplt got %0d/%h want 3/%h", cmplt_c, {c_uid, c_last}, {8'h56, 1'b1}); end
    endtask

    task automatic test_reset_mid_issue();
        send_uop(8'h77, 3'd4, 2'd3, 2'd0, 1'b1, 16'h0000, 5'd8, 5'd2, 1'b1);
        ld_if.req_rdy = 1'b0;
        #1;
        n_vec++; if ({ld_if.req_vld, ld_if.req_eidx} !== {1'b1, 4'd2}) begin n_err++; $display("FAIL rmid_pre got %h want %h", {ld_if.req_vld, ld_if.req_eidx}, {1'b1, 4'd2}); end
        step();
        rst = 1'b1;
        #1;
        n_vec++; if ({ld_if.req_vld, ld_if.uop_rdy, ld_if.cmplt_vld} !== 3'b000) begin n_err++; $display("FAIL rmid_cycle got %b want 000", {ld_if.req_vld, ld_if.uop_rdy, ld_if.cmplt_vld}); end
        step();
        #1;
        n_vec++; if ({ld_if.req_uid, ld_if.cmplt_uid, ld_if.req_eidx, ld_if.req_field} !== 22'd0) begin n_err++; $display("FAIL rmid_regs got %h want 0", {ld_if.req_uid, ld_if.cmplt_uid, ld_if.req_eidx, ld_if.req_field}); end
        n_vec++; if ((state_dbg !== IDLE) || (ld_if.uop_rdy !== 1'b0)) begin n_err++; $display("FAIL rmid_state got %0d/%b want 0/0", state_dbg, ld_if.uop_rdy); end
        rst = 1'b0;
        #1;
        n_vec++; if ({ld_if.uop_rdy, ld_if.cmplt_vld, ld_if.req_vld} !== 3'b100) begin n_err++; $display("FAIL rmid_release got %b want 100", {ld_if.uop_rdy, ld_if.cmplt_vld, ld_if.req_vld}); end
        step();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ld_if.uop_vld = 1'b0;
        ld_if.uop_uid = '0;
        ld_if.uop_type = '0;
        ld_if.uop_eew = '0;
        ld_if.uop_nf = '0;
        ld_if.uop_vm = 1'b0;
        ld_if.uop_vmask_data = '0;
        ld_if.uop_ele_len = '0;
        ld_if.uop_vstart_len = '0;
        ld_if.uop_op_last = 1'b0;
        ld_if.req_rdy = 1'b0;

        test_reset();
        test_unmasked();
        test_masked_seg();
        test_empty();
        test_back_to_back_stall();
        test_flush();
        test_reset_mid_issue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
